// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and encodings for the multicycle RV32I controller
//   state_t      controller FSM states
//   ALU_*        alu_control operation codes
//   OP_*         RV32I major opcodes handled by the controller
//   ALUOP_*      internal alu_op classes fed to alu_decoder
//   RES_/SRCA_/SRCB_/IMM_*  datapath mux select codes
//   imm_sel()    immediate format chosen from the opcode
package core_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      return (op == OP_STORE)  ? IMM_S :
             (op == OP_BRANCH) ? IMM_B :
             (op == OP_JAL)    ? IMM_J : IMM_I;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps alu_op class plus funct fields to the ALU operation code
//   alu_op      in  2  00 add, 01 sub, 10 decode funct3/funct7b5
//   funct3      in  3  instr[14:12]
//   funct7b5    in  1  instr[30]
//   op5         in  1  opcode[5], distinguishes R-type (sub allowed) from I-type
//   alu_control out 4  ALU operation
module alu_decoder
   import core_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [3:0] alu_control
);

   logic [3:0] funct_ctrl;

   always_comb begin
      funct_ctrl = ALU_ADD;
      case (funct3)
         // addi has no subtract form, so funct7b5 only selects SUB for R-type
         3'b000: funct_ctrl = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
         3'b001: funct_ctrl = ALU_SLL;
         3'b010: funct_ctrl = ALU_SLT;
         3'b011: funct_ctrl = ALU_SLTU;
         3'b100: funct_ctrl = ALU_XOR;
         3'b101: funct_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110: funct_ctrl = ALU_OR;
         3'b111: funct_ctrl = ALU_AND;
         default: funct_ctrl = ALU_ADD;
      endcase
      alu_control = (alu_op == ALUOP_SUB)   ? ALU_SUB :
                    (alu_op == ALUOP_FUNCT) ? funct_ctrl : ALU_ADD;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing the multicycle RV32I datapath
//   clk, reset (sync, active-high)
//   opcode/funct3/funct7b5 in  instruction fields from IR; zero in  ALU zero flag
//   pc_write, adr_src, mem_write, ir_write, reg_write             out enables/selects
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control         out datapath selects
//   instr_retire out  pulse in the last state of each instruction
//   illegal      out  sticky illegal-opcode flag
// Build option ILLEGAL_TRAP_EN: unknown opcodes halt the FSM and set illegal;
//   otherwise they retire as a NOP in DECODE and illegal stays 0.
module multicycle_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic                  funct7b5,
   input  logic                  zero,
   output logic                  pc_write,
   output logic                  adr_src,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic [1:0]            result_src,
   output logic [1:0]            alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            imm_src,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  instr_retire,
   output logic                  illegal
);

   state_t     state_q, state_d;
   logic       pc_update, branch, taken;
   logic [1:0] alu_op;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   always_ff @(posedge clk) begin
      if (reset) illegal_q <= 1'b0;
      else       illegal_q <= illegal_d;
   end

   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign imm_src = imm_sel(opcode);
   // beq (funct3=000) takes on zero, bne (funct3=001) on non-zero
   assign taken   = funct3[0] ? ~zero : zero;

   always_comb begin
      state_d      = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      illegal_d    = illegal_q;
`endif
      pc_update    = 1'b0;
      branch       = 1'b0;
      adr_src      = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      instr_retire = 1'b0;
      result_src   = RES_ALUOUT;
      alu_src_a    = SRCA_PC;
      alu_src_b    = SRCB_RD2;
      alu_op       = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_update  = 1'b1;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            // branch target is formed here so BEQ can load it from ALUOut
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
`else
                  // PC already advanced in FETCH, so dropping back is a NOP
                  state_d      = S_FETCH;
                  instr_retire = 1'b1;
`endif
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src   = RES_DATA;
            reg_write    = 1'b1;
            instr_retire = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src      = 1'b1;
            mem_write    = 1'b1;
            instr_retire = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write    = 1'b1;
            instr_retire = 1'b1;
         end
         S_BEQ: begin
            alu_src_a    = SRCA_RD1;
            alu_op       = ALUOP_SUB;
            branch       = 1'b1;
            instr_retire = 1'b1;
         end
         S_JAL: begin
            // return address OldPC+4 goes to ALUOut for ALUWB; PC takes the target
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
      pc_write = pc_update | (branch & taken);
      if (reset) begin
         pc_write     = 1'b0;
         mem_write    = 1'b0;
         ir_write     = 1'b0;
         reg_write    = 1'b0;
         instr_retire = 1'b0;
      end
   end

   alu_decoder u_alu_decoder (
      .alu_op     (alu_op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .op5        (opcode[5]),
      .alu_control(alu_control)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl against a per-instruction cycle model
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [3:0] alu_control;
   logic       instr_retire, illegal;

   multicycle_ctrl #(.ALU_CTRL_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
      .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
      .alu_control(alu_control), .instr_retire(instr_retire), .illegal(illegal)
   );

   always #5 clk = ~clk;

   localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4;
   localparam int A_SLT = 5, A_SLL = 6, A_SRL = 7, A_SRA = 8, A_SLTU = 9;
   localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

   typedef struct {
      logic [18:0] v;
      logic [18:0] m;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t steps[$];
   int   checks = 0;
   int   errors = 0;

   logic [18:0] act;
   assign act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                 alu_src_a, alu_src_b, imm_src, alu_control, instr_retire, illegal};

   // -1 marks a field the cycle leaves unconstrained
   function automatic exp_t cyc(input string tag, input int pcw, adr, mw, irw, rw, rs, a, b,
                                imm, aluc, ret, ill);
      exp_t e;
      int   val[12];
      int   w[12];
      int   lsb;
      val = '{ill, ret, aluc, imm, b, a, rs, rw, irw, mw, adr, pcw};
      w   = '{1, 1, 4, 2, 2, 2, 2, 1, 1, 1, 1, 1};
      e.v = '0;
      e.m = '0;
      e.tag = tag;
      lsb = 0;
      for (int i = 0; i < 12; i++) begin
         if (val[i] >= 0) begin
            e.v = e.v | 19'((val[i] & ((1 << w[i]) - 1)) << lsb);
            e.m = e.m | 19'(((1 << w[i]) - 1) << lsb);
         end
         lsb += w[i];
      end
      return e;
   endfunction

   function automatic int ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      case (f3)
         3'd0: return (f7 && op == RT) ? A_SUB : A_ADD;
         3'd1: return A_SLL;
         3'd2: return A_SLT;
         3'd3: return A_SLTU;
         3'd4: return A_XOR;
         3'd5: return f7 ? A_SRA : A_SRL;
         3'd6: return A_OR;
         default: return A_AND;
      endcase
   endfunction

   task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
      int imm;
      int tk;
      bit legal;
      imm = (op == ST) ? 1 : (op == BR) ? 2 : (op == JL) ? 3 : 0;
      legal = (op == LD) || (op == ST) || (op == RT) || (op == IT) || (op == BR) || (op == JL);
      tk = (f3[0] ? !z : z) ? 1 : 0;
      steps.delete();
      steps.push_back(cyc("fetch", 1, 0, 0, 1, 0, 2, 0, 2, imm, A_ADD, 0, 0));
`ifdef ILLEGAL_TRAP_EN
      steps.push_back(cyc("decode", 0, -1, 0, 0, 0, -1, 1, 1, imm, A_ADD, 0, 0));
      if (!legal)
         for (int i = 0; i < 10; i++)
            steps.push_back(cyc("halt", 0, -1, 0, 0, 0, -1, -1, -1, imm, -1, 0, 1));
`else
      steps.push_back(cyc("decode", 0, -1, 0, 0, 0, -1, 1, 1, imm, A_ADD, legal ? 0 : 1, 0));
`endif
      if (op == LD || op == ST)
         steps.push_back(cyc("memadr", 0, -1, 0, 0, 0, -1, 2, 1, imm, A_ADD, 0, 0));
      if (op == LD) begin
         steps.push_back(cyc("memread", 0, 1, 0, 0, 0, 0, -1, -1, imm, -1, 0, 0));
         steps.push_back(cyc("memwb", 0, -1, 0, 0, 1, 1, -1, -1, imm, -1, 1, 0));
      end
      if (op == ST)
         steps.push_back(cyc("memwrite", 0, 1, 1, 0, 0, 0, -1, -1, imm, -1, 1, 0));
      if (op == RT || op == IT)
         steps.push_back(cyc("execute", 0, -1, 0, 0, 0, -1, 2, (op == IT) ? 1 : 0, imm,
                             ref_alu(op, f3, f7), 0, 0));
      if (op == BR)
         steps.push_back(cyc("branch", tk, -1, 0, 0, 0, 0, 2, 0, imm, A_SUB, 1, 0));
      if (op == JL)
         steps.push_back(cyc("jal", 1, -1, 0, 0, 0, 0, 1, 2, imm, A_ADD, 0, 0));
      if (op == RT || op == IT || op == JL)
         steps.push_back(cyc("aluwb", 0, -1, 0, 0, 1, 0, -1, -1, imm, -1, 1, 0));
   endtask

   task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                      input logic z, input int abort);
      int n;
      model(op, f3, f7, z);
      n = steps.size();
      if (abort >= 0 && abort < n) n = abort + 1;
      for (int i = 0; i < n; i++)
         sb.push_back((i == abort) ? cyc("abort", 0, -1, 0, 0, 0, -1, -1, -1, -1, -1, 0, -1)
                                   : steps[i]);
      for (int i = 0; i < n; i++) begin
         reset = (i == abort);
         opcode = op;
         funct3 = f3;
         funct7b5 = f7;
         zero = z;
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ((act & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL %s: got %b want %b mask %b", e.tag, act, e.v, e.m);
         end
      end
   end

   initial begin
      logic [6:0] pool[8];
      logic [6:0] op;
      pool = '{LD, ST, RT, IT, BR, JL, 7'b1111111, 7'b0110111};
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(cyc("reset", 0, -1, 0, 0, 0, -1, -1, -1, -1, -1, 0, 0));
         reset = 1'b1;
         @(posedge clk);
         #1;
      end
      run(RT, 3'd0, 1'b1, 1'b0, -1);
      run(IT, 3'd0, 1'b1, 1'b0, -1);
      run(IT, 3'd5, 1'b1, 1'b0, -1);
      run(RT, 3'd5, 1'b0, 1'b0, -1);
      run(LD, 3'd2, 1'b0, 1'b0, -1);
      run(ST, 3'd2, 1'b0, 1'b1, -1);
      run(BR, 3'd0, 1'b0, 1'b1, -1);
      run(BR, 3'd0, 1'b0, 1'b0, -1);
      run(BR, 3'd1, 1'b0, 1'b1, -1);
      run(BR, 3'd1, 1'b0, 1'b0, -1);
      run(JL, 3'd0, 1'b0, 1'b0, -1);
      run(ST, 3'd2, 1'b0, 1'b0, 3);
      run(LD, 3'd2, 1'b0, 1'b0, 2);
`ifndef ILLEGAL_TRAP_EN
      run(7'b1111111, 3'd0, 1'b0, 1'b0, -1);
`endif
      for (int k = 0; k < 80; k++) begin
`ifdef ILLEGAL_TRAP_EN
         op = pool[$urandom_range(0, 5)];
`else
         op = pool[$urandom_range(0, 7)];
`endif
         run(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), -1);
      end
`ifdef ILLEGAL_TRAP_EN
      run(7'b1111111, 3'd0, 1'b0, 1'b0, -1);
      sb.push_back(cyc("trap_reset", 0, -1, 0, 0, 0, -1, -1, -1, -1, -1, 0, -1));
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      run(RT, 3'd7, 1'b0, 1'b0, -1);
`endif
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
